// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Lets instruction fetch (I, read-only) and the Memory stage (D, load/store) share one
//   variable-latency memory port. Each cycle, every request the pipeline presents is served
//   one at a time. D goes first because it belongs to the older instruction. Stall stays high
//   until all of those requests have completed. A watchdog aborts any access that waits
//   MAX_WAIT cycles for MemReady, and then sets the sticky Err flag.
// Ports
//   clk, reset                       clock; asynchronous active-low reset
//   IReq, IAddr, IRData              fetch request, address and returned word
//   DReq, DWE, DAddr, DWData,
//   DSize, DExt, DRData              data request, store enable, address, store data,
//                                    size/extension controls and returned load data
//   Stall                            freeze the pipeline registers this cycle
//   Err                              sticky watchdog-abort flag
//   MemReq, MemWE, MemAddr, MemWData,
//   MemSize, MemExt                  registered memory request, held until completion
//   MemRData, MemReady               memory read data and completion strobe
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IReq,
  input  logic [31:0] IAddr,
  output logic [31:0] IRData,
  input  logic        DReq,
  input  logic        DWE,
  input  logic [31:0] DAddr,
  input  logic [31:0] DWData,
  input  logic [1:0]  DSize,
  input  logic        DExt,
  output logic [31:0] DRData,
  output logic        Stall,
  output logic        Err,
  output logic        MemReq,
  output logic        MemWE,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic [1:0]  MemSize,
  output logic        MemExt,
  input  logic [31:0] MemRData,
  input  logic        MemReady
);

  typedef enum logic [1:0] {StIdle, StDAcc, StIAcc} state_e;

  localparam logic [7:0] WaitLimit = 8'(MAX_WAIT - 1);

  state_e     state;
  logic       iSrv, dSrv;
  logic [7:0] waitCnt;
  logic       iPend, dPend;

  // A request is pending until it has been served within the current pipeline cycle.
  assign iPend = IReq & ~iSrv;
  assign dPend = DReq & ~dSrv;
  assign Stall = reset & (iPend | dPend);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      iSrv     <= 1'b0;
      dSrv     <= 1'b0;
      waitCnt  <= 8'd0;
      Err      <= 1'b0;
      IRData   <= 32'd0;
      DRData   <= 32'd0;
      MemReq   <= 1'b0;
      MemWE    <= 1'b0;
      MemAddr  <= 32'd0;
      MemWData <= 32'd0;
      MemSize  <= 2'b00;
      MemExt   <= 1'b0;
    end else begin
      // The pipeline advances: forget what was served. A completion later in this block
      // still sets its flag, which covers a request that dropped mid-access.
      if (!Stall) begin
        iSrv <= 1'b0;
        dSrv <= 1'b0;
      end
      unique case (state)
        StIdle: begin
          if (dPend) begin
            state    <= StDAcc;
            waitCnt  <= 8'd0;
            MemReq   <= 1'b1;
            MemWE    <= DWE;
            MemAddr  <= DAddr;
            MemWData <= DWData;
            MemSize  <= DSize;
            MemExt   <= DExt;
          end else if (iPend) begin
            state    <= StIAcc;
            waitCnt  <= 8'd0;
            MemReq   <= 1'b1;
            MemWE    <= 1'b0;
            MemAddr  <= IAddr;
            MemWData <= 32'd0;
            MemSize  <= 2'b00;
            MemExt   <= 1'b0;
          end
        end
        StDAcc, StIAcc: begin
          if (MemReady) begin
            state  <= StIdle;
            MemReq <= 1'b0;
            if (state == StIAcc) begin
              IRData <= MemRData;
              iSrv   <= 1'b1;
            end else begin
              DRData <= MemWE ? 32'd0 : MemRData;
              dSrv   <= 1'b1;
            end
          end else if (waitCnt >= WaitLimit) begin
            // Watchdog abort: result reads as zero and the requester is released.
            state  <= StIdle;
            MemReq <= 1'b0;
            Err    <= 1'b1;
            if (state == StIAcc) begin
              IRData <= 32'd0;
              iSrv   <= 1'b1;
            end else begin
              DRData <= 32'd0;
              dSrv   <= 1'b1;
            end
          end else if (waitCnt != 8'hFF) begin
            waitCnt <= waitCnt + 8'd1;
          end
        end
        default: begin
          state  <= StIdle;
          MemReq <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. It acts as the memory itself. For each pipeline step it
// predicts the whole cycle trace: D first, then I. Each access adds one idle-stall cycle
// plus min(lat+1, MAX_WAIT) MemReq cycles, and one Stall=0 cycle closes the step.
// A negedge process compares the DUT against that trace.
module tb_mem_port_arbiter;

  localparam int unsigned MaxWait = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        IReq, DReq, DWE, DExt, MemReady;
  logic [31:0] IAddr, DAddr, DWData, MemRData;
  logic [1:0]  DSize;
  logic [31:0] IRData, DRData, MemAddr, MemWData;
  logic        Stall, Err, MemReq, MemWE, MemExt;
  logic [1:0]  MemSize;

  mem_port_arbiter #(.MAX_WAIT(MaxWait)) dut (
    .clk(clk), .reset(reset),
    .IReq(IReq), .IAddr(IAddr), .IRData(IRData),
    .DReq(DReq), .DWE(DWE), .DAddr(DAddr), .DWData(DWData), .DSize(DSize), .DExt(DExt),
    .DRData(DRData), .Stall(Stall), .Err(Err),
    .MemReq(MemReq), .MemWE(MemWE), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemSize(MemSize), .MemExt(MemExt), .MemRData(MemRData), .MemReady(MemReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, mreq, we, ext, err;
    logic [31:0] addr, wdata, ir, dr;
    logic [1:0]  size;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] expIR, expDR;
  logic        expErr;
  int          total = 0;
  int          bad = 0;
  int          stallCnt = 0;
  bit          chkEn = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chkEn) begin
      if (expQ.size() == 0) begin
        total++;
        bad++;
        $display("FAIL trace: no expectation queued at %0t", $time);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        chk("Stall", 32'(Stall), 32'(e.stall));
        chk("MemReq", 32'(MemReq), 32'(e.mreq));
        chk("IRData", IRData, e.ir);
        chk("DRData", DRData, e.dr);
        chk("Err", 32'(Err), 32'(e.err));
        if (e.mreq) begin
          chk("MemWE", 32'(MemWE), 32'(e.we));
          chk("MemAddr", MemAddr, e.addr);
          chk("MemSize", 32'(MemSize), 32'(e.size));
          chk("MemExt", 32'(MemExt), 32'(e.ext));
          if (e.we) chk("MemWData", MemWData, e.wdata);
        end
      end
    end
    if (Stall) stallCnt++;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic st, input logic mq, input logic we,
                         input logic [31:0] a, input logic [31:0] w,
                         input logic [1:0] sz, input logic ex);
    exp_t e;
    e.stall = st; e.mreq = mq; e.we = we; e.addr = a; e.wdata = w; e.size = sz; e.ext = ex;
    e.ir = expIR; e.dr = expDR; e.err = expErr;
    expQ.push_back(e);
  endtask

  // One pipeline step. Called at cycle start; returns at the start of the next step's cycle.
  task automatic doStep(input logic ir, input logic dr, input logic dwe,
                        input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                        input logic [1:0] dsz, input logic dext,
                        input int latD, input int latI,
                        input logic [31:0] rdD, input logic [31:0] rdI);
    IReq = ir; DReq = dr; DWE = dwe; IAddr = ia; DAddr = da; DWData = dwd;
    DSize = dsz; DExt = dext;
    stallCnt = 0;
    for (int a = 0; a < 2; a++) begin
      bit   isD;
      int   lat, dur;
      bit   abrt;
      isD = (a == 0);
      if (isD ? dr : ir) begin
        MemReady = 1'($urandom_range(0, 1));
        MemRData = $urandom;
        pushExp(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
        cyc();
        lat  = isD ? latD : latI;
        abrt = (lat >= int'(MaxWait));
        dur  = abrt ? int'(MaxWait) : lat + 1;
        for (int j = 0; j < dur; j++) begin
          MemReady = (j == lat);
          MemRData = (j == lat) ? (isD ? rdD : rdI) : $urandom;
          if (isD) pushExp(1'b1, 1'b1, dwe, da, dwd, dsz, dext);
          else     pushExp(1'b1, 1'b1, 1'b0, ia, 32'd0, 2'b00, 1'b0);
          cyc();
        end
        if (isD) expDR = (abrt || dwe) ? 32'd0 : rdD;
        else     expIR = abrt ? 32'd0 : rdI;
        if (abrt) expErr = 1'b1;
      end
    end
    MemReady = 1'($urandom_range(0, 1));
    MemRData = $urandom;
    pushExp(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 2'b00, 1'b0);
    cyc();
  endtask

  initial begin
    expIR = 32'd0; expDR = 32'd0; expErr = 1'b0;
    reset = 1'b0;
    IReq = 1'b1; DReq = 1'b1; DWE = 1'b0; DExt = 1'b0; DSize = 2'b00;
    IAddr = 32'd0; DAddr = 32'd0; DWData = 32'd0; MemReady = 1'b1; MemRData = 32'hFFFF_FFFF;
    #12;
    chk("rst Stall", 32'(Stall), 32'd0);
    chk("rst MemReq", 32'(MemReq), 32'd0);
    chk("rst MemAddr", MemAddr, 32'd0);
    chk("rst IRData", IRData, 32'd0);
    chk("rst Err", 32'(Err), 32'd0);
    IReq = 1'b0; DReq = 1'b0; MemReady = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chkEn = 1'b1;

    // Fetch 0x100, ready 3 cycles after MemReq.
    doStep(1'b1, 1'b0, 1'b0, 32'h100, 32'd0, 32'd0, 2'b00, 1'b0, 0, 3, 32'd0, 32'hDEADBEEF);
    chk("t2 stall cycles", 32'(stallCnt), 32'd5);
    chk("t2 IRData", IRData, 32'hDEADBEEF);
    chk("t2 MemAddr", MemAddr, 32'h100);
    chk("t2 MemWE", 32'(MemWE), 32'd0);

    // Simultaneous store + fetch: store first, then fetch.
    doStep(1'b1, 1'b1, 1'b1, 32'h200, 32'h40, 32'h1234, 2'b10, 1'b0, 1, 0,
           32'h5555_AAAA, 32'h0BAD_F00D);
    chk("t3 stall cycles", 32'(stallCnt), 32'd5);
    chk("t3 DRData", DRData, 32'd0);
    chk("t3 last MemAddr", MemAddr, 32'h200);
    chk("t3 IRData", IRData, 32'h0BAD_F00D);

    // Load with size/ext, ready in the first MemReq cycle.
    doStep(1'b0, 1'b1, 1'b0, 32'd0, 32'h80, 32'd0, 2'b01, 1'b1, 0, 0, 32'hCAFEF00D, 32'd0);
    chk("t4 stall cycles", 32'(stallCnt), 32'd2);
    chk("t4 DRData", DRData, 32'hCAFEF00D);
    chk("t4 MemSize", 32'(MemSize), 32'd1);
    chk("t4 MemExt", 32'(MemExt), 32'd1);

    // Back-to-back fetches with IReq held high.
    doStep(1'b1, 1'b0, 1'b0, 32'h300, 32'd0, 32'd0, 2'b00, 1'b0, 0, 0, 32'd0, 32'h1111_1111);
    chk("t6 first stall", 32'(stallCnt), 32'd2);
    doStep(1'b1, 1'b0, 1'b0, 32'h304, 32'd0, 32'd0, 2'b00, 1'b0, 0, 1, 32'd0, 32'h2222_2222);
    chk("t6 second stall", 32'(stallCnt), 32'd3);
    chk("t6 IRData", IRData, 32'h2222_2222);

    // Memory never ready: watchdog aborts after MaxWait MemReq cycles.
    doStep(1'b1, 1'b0, 1'b0, 32'h400, 32'd0, 32'd0, 2'b00, 1'b0, 0, 50, 32'd0, 32'h7777_7777);
    chk("t5 stall cycles", 32'(stallCnt), 32'd5);
    chk("t5 IRData", IRData, 32'd0);
    chk("t5 Err", 32'(Err), 32'd1);
    doStep(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 0, 0, 32'd0, 32'd0);
    chk("t5 Err sticky", 32'(Err), 32'd1);

    // Reset in the middle of a D access.
    chkEn = 1'b0;
    IReq = 1'b0; DReq = 1'b1; DWE = 1'b0; DAddr = 32'h500; MemReady = 1'b0;
    cyc();
    chk("t1 MemReq before", 32'(MemReq), 32'd1);
    reset = 1'b0;
    #1;
    chk("t1 MemReq", 32'(MemReq), 32'd0);
    chk("t1 Stall", 32'(Stall), 32'd0);
    chk("t1 Err", 32'(Err), 32'd0);
    DReq = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
    chk("t1 idle MemReq", 32'(MemReq), 32'd0);
    chk("t1 idle Stall", 32'(Stall), 32'd0);
    expIR = 32'd0; expDR = 32'd0; expErr = 1'b0;
    expQ.delete();
    chkEn = 1'b1;

    for (int n = 0; n < 200; n++) begin
      doStep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 5)),
             int'($urandom_range(0, 5)), $urandom, $urandom);
    end
    chkEn = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
